// File: rtl/washer_input_conditioner.sv
// Conditions the raw washer panel inputs: synchronize, debounce, edge-detect Start, gate load.
// Latency: a held raw change reaches the stable value 2+DEBOUNCE_CYCLES edges later; outputs one edge after that.
// No backpressure: every output is a registered level or a one-cycle pulse, so there is no flow control.

// One debounce channel: one stable register plus one counter, for a WIDTH-bit vector.
module washer_debounce_chan #(
  parameter int       WIDTH             = 1,
  parameter int       DEBOUNCE_CYCLES   = 16,
  parameter bit       RESTART_ON_CHANGE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] synced_i,
  input  logic [WIDTH-1:0] next_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Count consecutive samples that differ from stable; accept on the last one.
  // For vector channels, a new code arriving while pending (visible one flop early
  // on next_i) zeroes the count so the new code starts its own full window.
  // An accept on the final sample still wins over that restart.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (synced_i == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = synced_i;
      cnt_d    = '0;
    end else if (RESTART_ON_CHANGE && (next_i != synced_i)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

module washer_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       door_sw,
  input  logic [1:0] load_sw,
  input  logic       load_lock,
  output logic       Start,
  output logic       Door,
  output logic [1:0] load,
  output logic       start_rejected
);

  // Bit map of the synchronizer: [0] start, [1] door, [3:2] load.
  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q;

  logic       start_stable;
  logic       door_stable;
  logic [1:0] load_stable;

  logic       start_prev_q;
  logic       start_q, start_d;
  logic       rej_q, rej_d;
  logic [1:0] load_q, load_d;
  logic       start_rise;

  assign raw = {load_sw, door_sw, start_btn};

  // Two-flop synchronizer on every raw input bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  washer_debounce_chan #(
    .WIDTH            (1),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .RESTART_ON_CHANGE(1'b0)
  ) u_start (
    .clk     (clk),
    .reset   (reset),
    .synced_i(sync2_q[0]),
    .next_i  (sync1_q[0]),
    .stable_o(start_stable)
  );

  washer_debounce_chan #(
    .WIDTH            (1),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .RESTART_ON_CHANGE(1'b0)
  ) u_door (
    .clk     (clk),
    .reset   (reset),
    .synced_i(sync2_q[1]),
    .next_i  (sync1_q[1]),
    .stable_o(door_stable)
  );

  washer_debounce_chan #(
    .WIDTH            (2),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .RESTART_ON_CHANGE(1'b1)
  ) u_load (
    .clk     (clk),
    .reset   (reset),
    .synced_i(sync2_q[3:2]),
    .next_i  (sync1_q[3:2]),
    .stable_o(load_stable)
  );

  // Rising edge of the debounced start decides Start vs reject using the door
  // register as it stands this cycle, so a simultaneous door update is not seen.
  always_comb begin
    start_rise = start_stable & ~start_prev_q;
    start_d    = start_rise & ~door_stable;
    rej_d      = start_rise & door_stable;
    load_d     = load_lock ? load_q : load_stable;
  end

  // Output registers and the start edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_prev_q <= 1'b0;
      start_q      <= 1'b0;
      rej_q        <= 1'b0;
      load_q       <= 2'b00;
    end else begin
      start_prev_q <= start_stable;
      start_q      <= start_d;
      rej_q        <= rej_d;
      load_q       <= load_d;
    end
  end

  assign Start          = start_q;
  assign start_rejected = rej_q;
  assign Door           = door_stable;
  assign load           = load_q;

endmodule

// File: tb/tb_washer_input_conditioner.sv
// Directed bench for washer_input_conditioner with DEBOUNCE_CYCLES=4.
// Latency under test: stable at edge 2+4, pulse one edge later.
// Inputs change 1ns after a rising edge; outputs are read at the same point.

module tb_washer_input_conditioner;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       door_sw;
  logic [1:0] load_sw;
  logic       load_lock;
  logic       Start;
  logic       Door;
  logic [1:0] load;
  logic       start_rejected;

  int   checks = 0;
  int   errors = 0;
  int   n_start = 0;
  int   n_rej = 0;
  int   viol = 0;
  logic prev_pulse = 1'b0;

  typedef struct {
    logic       st;
    logic       dr;
    logic [1:0] ld;
    logic       lk;
    int         cyc;
    int         ns;
    int         nr;
    logic       edoor;
    logic [1:0] eload;
  } vec_t;

  vec_t tbl [15];

  always #5 clk = ~clk;

  washer_input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_btn     (start_btn),
    .door_sw       (door_sw),
    .load_sw       (load_sw),
    .load_lock     (load_lock),
    .Start         (Start),
    .Door          (Door),
    .load          (load),
    .start_rejected(start_rejected)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One rising edge, then sample and tally pulses and pulse-rule violations.
  task automatic tick();
    @(posedge clk);
    #1;
    if (Start) n_start++;
    if (start_rejected) n_rej++;
    if (Start && start_rejected) viol++;
    if ((Start || start_rejected) && prev_pulse) viol++;
    prev_pulse = Start | start_rejected;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int r0;
    int bad;

    // inputs: st dr ld lk cyc | expected #Start #rej Door load
    tbl[0]  = '{1'b0, 1'b0, 2'b00, 1'b0,  4, 0, 0, 1'b0, 2'b00};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 10, 1, 0, 1'b0, 2'b00};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 10, 0, 0, 1'b0, 2'b00};
    tbl[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 10, 0, 0, 1'b0, 2'b00};
    tbl[4]  = '{1'b0, 1'b1, 2'b00, 1'b0, 10, 0, 0, 1'b1, 2'b00};
    tbl[5]  = '{1'b1, 1'b1, 2'b00, 1'b0, 10, 0, 1, 1'b1, 2'b00};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 1'b0, 10, 0, 0, 1'b0, 2'b00};
    tbl[7]  = '{1'b1, 1'b0, 2'b00, 1'b0, 10, 1, 0, 1'b0, 2'b00};
    tbl[8]  = '{1'b0, 1'b0, 2'b00, 1'b0, 10, 0, 0, 1'b0, 2'b00};
    tbl[9]  = '{1'b0, 1'b0, 2'b10, 1'b0, 10, 0, 0, 1'b0, 2'b10};
    tbl[10] = '{1'b0, 1'b0, 2'b11, 1'b1, 10, 0, 0, 1'b0, 2'b10};
    tbl[11] = '{1'b0, 1'b0, 2'b11, 1'b0,  1, 0, 0, 1'b0, 2'b11};
    tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b0, 10, 0, 0, 1'b0, 2'b00};
    tbl[13] = '{1'b1, 1'b1, 2'b00, 1'b0, 10, 0, 1, 1'b1, 2'b00};
    tbl[14] = '{1'b0, 1'b0, 2'b00, 1'b0, 10, 0, 0, 1'b0, 2'b00};

    // Reset state, driven asynchronously before any clock edge.
    reset     = 1'b0;
    start_btn = 1'b0;
    door_sw   = 1'b0;
    load_sw   = 2'b00;
    load_lock = 1'b0;
    #3;
    chk("reset_Start", Start, 0);
    chk("reset_rej", start_rejected, 0);
    chk("reset_Door", Door, 0);
    chk("reset_load", load, 0);
    ticks(2);
    reset = 1'b1;
    ticks(2);

    // Single press, door closed: Start exactly after edge 7.
    start_btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("press_Start_e%0d", k), Start, (k == 7) ? 1 : 0);
      chk($sformatf("press_rej_e%0d", k), start_rejected, 0);
    end
    start_btn = 1'b0;
    ticks(10);

    // Bounces of 1, 2 and 3 cycles must not be accepted.
    s0 = n_start;
    r0 = n_rej;
    for (int w = 1; w <= 3; w++) begin
      start_btn = 1'b1;
      ticks(w);
      start_btn = 1'b0;
      ticks(6);
    end
    ticks(4);
    chk("glitch_nstart", n_start - s0, 0);
    chk("glitch_nrej", n_rej - r0, 0);
    chk("glitch_cnt", dut.u_start.cnt_q, 0);
    chk("glitch_Start", Start, 0);

    // Level table.
    foreach (tbl[i]) begin
      start_btn = tbl[i].st;
      door_sw   = tbl[i].dr;
      load_sw   = tbl[i].ld;
      load_lock = tbl[i].lk;
      s0 = n_start;
      r0 = n_rej;
      ticks(tbl[i].cyc);
      chk($sformatf("tbl%0d_nstart", i), n_start - s0, tbl[i].ns);
      chk($sformatf("tbl%0d_nrej", i), n_rej - r0, tbl[i].nr);
      chk($sformatf("tbl%0d_Door", i), Door, tbl[i].edoor);
      chk($sformatf("tbl%0d_load", i), load, tbl[i].eload);
    end

    // Load 00 -> 01 (2 cycles) -> 11: the 01 never appears, 11 arrives at edge 9.
    bad = 0;
    load_sw = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) load_sw = 2'b11;
      tick();
      if (load == 2'b01) bad++;
      chk($sformatf("load_seq_e%0d", k), load, (k >= 9) ? 3 : 0);
    end
    chk("load_never_01", bad, 0);

    // Door rises in the same cycle Start is decided: old door (closed) wins.
    s0 = n_start;
    r0 = n_rej;
    start_btn = 1'b1;
    tick();
    door_sw = 1'b1;
    ticks(10);
    chk("race_open_nstart", n_start - s0, 1);
    chk("race_open_nrej", n_rej - r0, 0);
    start_btn = 1'b0;
    ticks(10);

    // Door falls in the same cycle Start is decided: old door (open) wins.
    s0 = n_start;
    r0 = n_rej;
    start_btn = 1'b1;
    tick();
    door_sw = 1'b0;
    ticks(10);
    chk("race_close_nstart", n_start - s0, 0);
    chk("race_close_nrej", n_rej - r0, 1);
    start_btn = 1'b0;
    ticks(10);

    // Reset during a pending start count, press held through release.
    door_sw = 1'b1;
    load_sw = 2'b10;
    ticks(10);
    chk("prerst_Door", Door, 1);
    chk("prerst_load", load, 2);
    door_sw   = 1'b0;
    start_btn = 1'b1;
    ticks(4);
    chk("prerst_cnt", dut.u_start.cnt_q, 2);
    reset = 1'b0;
    #1;
    chk("rst_Start", Start, 0);
    chk("rst_rej", start_rejected, 0);
    chk("rst_Door", Door, 0);
    chk("rst_load", load, 0);
    ticks(2);
    reset = 1'b1;
    r0 = n_rej;
    s0 = n_start;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rel_Start_e%0d", k), Start, (k == 7) ? 1 : 0);
    end
    chk("rel_nstart", n_start - s0, 1);
    chk("rel_nrej", n_rej - r0, 0);
    start_btn = 1'b0;
    ticks(10);

    chk("pulse_rules", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/washer_input_conditioner.md
WASHER_INPUT_CONDITIONER -- requirements
Module: washer_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, range 2..65535: number of consecutive stable synchronized samples needed to accept a new input value.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low.
REQ-004 start_btn  input  1  raw, asynchronous, bouncing Start pushbutton (1 = pressed).
REQ-005 door_sw  input  1  raw, asynchronous, bouncing door switch (1 = door open).
REQ-006 load_sw  input  2  raw, asynchronous load-size selector switches.
REQ-007 load_lock  input  1  synchronous; 1 = freeze the load output (cycle in progress).
REQ-008 Start  output  1  registered one-cycle pulse: clean Start request to the washer controller.
REQ-009 Door  output  1  registered debounced door level (1 = open).
REQ-010 load  output  2  registered debounced load code, subject to load_lock.
REQ-011 start_rejected  output  1  registered one-cycle pulse: accepted press discarded because the door was open.

Function
REQ-012 Each raw input bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 There SHALL be three debounce channels: start (1 bit), door (1 bit), and load (2 bits treated as one vector). Each channel SHALL have its own stable register and its own counter.
REQ-014 Per channel, on each clock: if synced == stable, then counter <= 0. Otherwise, if counter == DEBOUNCE_CYCLES-1, then stable <= synced and counter <= 0. Otherwise counter <= counter+1.
REQ-015 The load channel SHALL compare the whole 2-bit vector. Any change of the synced vector while pending restarts the count, and the count SHALL be 0 on the next cycle. An intermediate code SHALL never reach stable unless it is held for DEBOUNCE_CYCLES samples.
REQ-016 A raw change held steady SHALL update stable exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-017 A glitch or bounce shorter than DEBOUNCE_CYCLES synced cycles SHALL leave stable and all outputs unchanged.
REQ-018 Counter width SHALL be clog2(DEBOUNCE_CYCLES). The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 Door SHALL equal the door channel stable value.
REQ-020 A 0->1 transition of the start stable value SHALL produce a one-cycle event on the following edge:
- Start=1 if the door stable value is 0 in that cycle;
- otherwise start_rejected=1.
REQ-021 Start and start_rejected SHALL never be high together. Neither SHALL be high for two consecutive cycles.
REQ-022 Holding start_btn pressed SHALL yield exactly one event. Release (1->0) SHALL yield no event.
REQ-023 A start rising event and a door stable change in the same cycle: the door value before the update (the current stable register) SHALL decide between Start and start_rejected.
REQ-024 When load_lock=0, load <= load stable value every cycle. When load_lock=1, load SHALL hold its value.
REQ-025 On load_lock 1->0, load SHALL take the current load stable value on the next edge.
REQ-026 Debouncing SHALL continue while load_lock=1.
REQ-027 There SHALL be no combinational path from any input to any output.

Reset
REQ-028 When reset=0, asynchronously:
- all synchronizer flops, stable registers and counters SHALL be 0;
- Start=0, start_rejected=0, Door=0, load=2'b00.
REQ-029 Reset asserted mid-debounce or mid-pulse SHALL discard the pending state. No event SHALL be generated on reset release.
REQ-030 After reset release, inputs already at 1 SHALL be accepted through the normal REQ-016 latency. For start, this yields a Start or start_rejected event.

Verification
REQ-031 DEBOUNCE_CYCLES=4, door_sw=0, start_btn 0->1 held -> stable at edge 6, Start=1 for exactly one cycle after edge 7, start_rejected=0.
REQ-032 start_btn toggles with 1-, 2- and 3-cycle pulses, then returns to 0 -> Start, start_rejected and the counters end at 0, with no pulse.
REQ-033 door_sw=1 debounced, then start press -> start_rejected single pulse, Start=0. Door closed then second press -> Start pulse.
REQ-034 load_sw 00->01->11 with the 01 held 2 cycles, then 11 held -> load goes 00->11 directly, never 01.
REQ-035 load_lock=1, load_sw changes to 10 and is debounced -> load stays 00. Drop load_lock -> load=10 one edge later.
REQ-036 reset=0 pulse during a pending start count (counter=2) -> all outputs 0 immediately. start_btn held through release -> exactly one Start at 2+4+1 edges after release.
